// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer in front of an FFT core and its reorder stage.
// Launches whole, gap-free frames of FFT_SIZE samples into the core. Each launch
// is gated on downstream credits and on the number of frames in flight. The
// reordered output is framed with first/last markers, and sticky error flags
// report framing, underrun, alignment and credit problems.
//
// Handshake: a sample transfers on s_data in every cycle where s_valid && s_ready
// are both high at the rising clock edge. In IDLE, s_ready reflects launch
// eligibility and does not depend on s_valid. In RUN, s_ready is held high and
// the controller issues exactly one sample per cycle. If s_valid is low in RUN,
// a zero sample is padded in. The m_* output has no backpressure.
//
// Complex samples are packed as {re[DW-1:0], im[DW-1:0]}.
module fft_frame_ctrl #(
  parameter int FFT_SIZE   = 16,
  parameter int CREDITS    = 64,
  parameter int MAX_FLIGHT = 4,
  parameter int DW         = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [2*DW-1:0]                   s_data,
  input  logic                              s_valid,
  input  logic                              s_last,
  output logic                              s_ready,
  output logic [2*DW-1:0]                   fft_din,
  output logic                              fft_din_valid,
  input  logic [2*DW-1:0]                   fft_dout,
  input  logic                              fft_dout_valid,
  output logic [2*DW-1:0]                   m_data,
  output logic                              m_valid,
  output logic                              m_first,
  output logic                              m_last,
  input  logic                              credit_ret,
  output logic [$clog2(MAX_FLIGHT+1)-1:0]   frames_in_flight,
  input  logic                              err_clr,
  output logic                              err_framing,
  output logic                              err_underrun,
  output logic                              err_align,
  output logic                              err_credit
);

  localparam int CW = $clog2(FFT_SIZE);
  localparam int KW = $clog2(CREDITS + 1);
  localparam int FW = $clog2(MAX_FLIGHT + 1);

  localparam logic [CW-1:0] LAST_IDX   = CW'(FFT_SIZE - 1);
  localparam logic [KW-1:0] CRED_MAX   = KW'(CREDITS);
  localparam logic [KW-1:0] CRED_FRAME = KW'(FFT_SIZE);
  localparam logic [FW-1:0] FLIGHT_MAX = FW'(MAX_FLIGHT);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   in_cnt;
  logic [CW-1:0]   out_cnt;
  logic [KW-1:0]   credits;

  logic            elig;
  logic            accept;
  logic            launch;
  logic [CW-1:0]   frame_pos;
  logic            framing_set;
  logic            underrun_set;
  logic            stray;
  logic            gap;
  logic            done;
  logic            credit_set;

  // Launch eligibility, handshake and error-set conditions
  always_comb begin
    elig         = (credits >= CRED_FRAME) && (frames_in_flight < FLIGHT_MAX);
    s_ready      = rst_n && ((state == RUN) || elig);
    accept       = s_valid && s_ready;
    // Every frame starts from IDLE. The FSM drops back to IDLE after the last
    // sample, so an eligible stream is accepted again on the very next cycle
    // and consecutive frames stay gap-free.
    launch       = (state == IDLE) && accept;
    frame_pos    = (state == IDLE) ? '0 : in_cnt;
    framing_set  = accept && s_last && (frame_pos != LAST_IDX);
    underrun_set = (state == RUN) && !s_valid;
    // Output beat with nothing outstanding and no frame in progress
    stray        = fft_dout_valid && (frames_in_flight == '0) && (out_cnt == '0);
    // Valid dropped in the middle of an output frame
    gap          = !fft_dout_valid && (out_cnt != '0);
    done         = (fft_dout_valid && !stray && (out_cnt == LAST_IDX)) || gap;
    credit_set   = credit_ret && !launch && (credits == CRED_MAX);
  end

  // Input FSM: frame sequencing and registered issue to the FFT core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_cnt        <= '0;
      fft_din       <= '0;
      fft_din_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= RUN;
            in_cnt        <= CW'(1);
            fft_din       <= s_data;
            fft_din_valid <= 1'b1;
          end else begin
            fft_din       <= '0;
            fft_din_valid <= 1'b0;
          end
        end
        RUN: begin
          // A missing sample is padded with complex zero; the frame is never cut short
          fft_din       <= s_valid ? s_data : '0;
          fft_din_valid <= 1'b1;
          if (in_cnt == LAST_IDX) begin
            in_cnt <= '0;
            state  <= IDLE;
          end else begin
            in_cnt <= in_cnt + CW'(1);
          end
        end
        default: begin
          state         <= IDLE;
          in_cnt        <= '0;
          fft_din       <= '0;
          fft_din_valid <= 1'b0;
        end
      endcase
    end
  end

  // Output register stage: framing markers and output beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
      out_cnt <= '0;
    end else begin
      m_data  <= fft_dout_valid ? fft_dout : '0;
      m_valid <= fft_dout_valid;
      m_first <= fft_dout_valid && (out_cnt == '0);
      m_last  <= fft_dout_valid && (out_cnt == LAST_IDX);
      if (gap) begin
        out_cnt <= '0;
      end else if (fft_dout_valid && !stray) begin
        out_cnt <= out_cnt + CW'(1);
      end
    end
  end

  // Downstream credit pool and in-flight frame count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits          <= CRED_MAX;
      frames_in_flight <= '0;
    end else begin
      if (launch) begin
        credits <= credits - CRED_FRAME + KW'(credit_ret);
      end else if (credit_ret && (credits != CRED_MAX)) begin
        credits <= credits + KW'(1);
      end
      if (launch && !done) begin
        frames_in_flight <= frames_in_flight + FW'(1);
      end else if (done && !launch && (frames_in_flight != '0)) begin
        frames_in_flight <= frames_in_flight - FW'(1);
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_framing  <= 1'b0;
      err_underrun <= 1'b0;
      err_align    <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      err_framing  <= framing_set  || (err_framing  && !err_clr);
      err_underrun <= underrun_set || (err_underrun && !err_clr);
      err_align    <= stray || gap || (err_align    && !err_clr);
      err_credit   <= credit_set   || (err_credit   && !err_clr);
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed bench for fft_frame_ctrl. The bench plays the role
// of the FFT core on the output side. The DUT is built with CREDITS = 32, so two
// frames exhaust the credit pool.
module tb_fft_frame_ctrl;

  localparam int N    = 16;
  localparam int CRED = 32;
  localparam int MAXF = 4;
  localparam int DW   = 16;
  localparam int W    = 2 * DW;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [W-1:0]  fft_din;
  logic          fft_din_valid;
  logic [W-1:0]  fft_dout;
  logic          fft_dout_valid;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_first;
  logic          m_last;
  logic          credit_ret;
  logic [2:0]    frames_in_flight;
  logic          err_clr;
  logic          err_framing;
  logic          err_underrun;
  logic          err_align;
  logic          err_credit;

  fft_frame_ctrl #(
    .FFT_SIZE  (N),
    .CREDITS   (CRED),
    .MAX_FLIGHT(MAXF),
    .DW        (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_ready         (s_ready),
    .fft_din         (fft_din),
    .fft_din_valid   (fft_din_valid),
    .fft_dout        (fft_dout),
    .fft_dout_valid  (fft_dout_valid),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_first         (m_first),
    .m_last          (m_last),
    .credit_ret      (credit_ret),
    .frames_in_flight(frames_in_flight),
    .err_clr         (err_clr),
    .err_framing     (err_framing),
    .err_underrun    (err_underrun),
    .err_align       (err_align),
    .err_credit      (err_credit)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int din_run  = 0;
  int last_run = 0;

  logic [W-1:0] exp_din_q[$];
  logic [W+2:0] exp_out_q[$];   // {check_marks, first, last, data}
  logic [W-1:0] e_din;
  logic [W+2:0] e_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  function automatic logic [W-1:0] sample(input int k);
    logic [15:0] re;
    re = 16'(k);
    return {re, ~re};
  endfunction

  function automatic logic [W-1:0] dout_word(input int k);
    logic [15:0] lo;
    lo = 16'(k);
    return {16'hA5A5 ^ lo, lo};
  endfunction

  // One 16-slot input frame; gap_a/gap_b mark slots with s_valid low,
  // last_at marks the slot carrying s_last, clr_at the slot carrying err_clr
  task automatic send_frame(input int first_k, input int gap_a, input int gap_b,
                            input int last_at, input int clr_at);
    for (int i = 1; i <= N; i++) begin
      s_data  = sample(first_k + i - 1);
      s_valid = !(i == gap_a || i == gap_b);
      s_last  = (i == last_at);
      err_clr = (i == clr_at);
      exp_din_q.push_back(s_valid ? s_data : '0);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    err_clr = 1'b0;
    s_data  = '0;
  endtask

  task automatic return_credits(input int n);
    credit_ret = 1'b1;
    repeat (n) step();
    credit_ret = 1'b0;
  endtask

  // Output beats starting at frame position 0; check_marks=0 skips first/last checks
  task automatic send_beats(input int n, input int base, input bit check_marks);
    for (int i = 0; i < n; i++) begin
      int pos;
      pos            = i % N;
      fft_dout       = dout_word(base + i);
      fft_dout_valid = 1'b1;
      exp_out_q.push_back({check_marks, 1'(pos == 0), 1'(pos == N - 1), fft_dout});
      step();
    end
  endtask

  // Scoreboard: pop expected values whenever the DUT produces output
  always @(negedge clk) begin
    if (fft_din_valid) begin
      din_run++;
      if (exp_din_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL din_extra observed=%0h expected=none", fft_din);
      end else begin
        e_din = exp_din_q.pop_front();
        check("fft_din", fft_din, e_din);
      end
    end else if (din_run != 0) begin
      last_run = din_run;
      din_run  = 0;
    end
    if (m_valid) begin
      if (exp_out_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL m_extra observed=%0h expected=none", m_data);
      end else begin
        e_out = exp_out_q.pop_front();
        check("m_data", m_data, e_out[W-1:0]);
        if (e_out[W+2]) begin
          check("m_first", m_first, e_out[W+1]);
          check("m_last", m_last, e_out[W]);
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    s_data         = '0;
    s_valid        = 1'b0;
    s_last         = 1'b0;
    fft_dout       = '0;
    fft_dout_valid = 1'b0;
    credit_ret     = 1'b0;
    err_clr        = 1'b0;
    cycles(3);

    // Reset state
    check("rst_s_ready", s_ready, 0);
    check("rst_din_valid", fft_din_valid, 0);
    check("rst_fft_din", fft_din, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_marks", {m_first, m_last}, 0);
    check("rst_fif", frames_in_flight, 0);
    check("rst_errs", {err_framing, err_underrun, err_align, err_credit}, 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", s_ready, 1);

    // Single contiguous frame, s_last on the 16th sample
    check("t1_din_idle", fft_din_valid, 0);
    send_frame(1, 0, 0, 16, 0);
    cycles(2);
    check("t1_run_len", last_run, 16);
    check("t1_fif", frames_in_flight, 1);
    check("t1_errs", {err_framing, err_underrun, err_align, err_credit}, 0);
    check("t1_ready", s_ready, 1);

    // Refill to saturation, then one extra return
    return_credits(16);
    check("cred_full_ok", err_credit, 0);
    return_credits(1);
    check("cred_over", err_credit, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("cred_clr", err_credit, 0);

    // 32 contiguous samples: two back-to-back frames
    send_frame(17, 0, 0, 16, 0);
    send_frame(33, 0, 0, 16, 0);
    cycles(2);
    check("t2_run_len", last_run, 32);
    check("t2_fif", frames_in_flight, 3);
    check("t2_errs", {err_framing, err_underrun}, 0);
    check("t2_ready_no_cred", s_ready, 0);
    send_beats(16, 0, 1);
    check("t2_fif_after_f1", frames_in_flight, 2);
    send_beats(16, 16, 1);
    check("t2_fif_after_f2", frames_in_flight, 1);
    send_beats(16, 32, 1);
    fft_dout_valid = 1'b0;
    check("t2_fif_after_f3", frames_in_flight, 0);
    step();
    check("t2_align", err_align, 0);

    // Credit return burst re-enables s_ready only when 16 are back
    return_credits(15);
    check("t3_ready_15", s_ready, 0);
    return_credits(1);
    check("t3_ready_16", s_ready, 1);

    // Underrun on slots 5 and 6: zero padding, frame length unchanged
    send_frame(50, 5, 6, 16, 0);
    cycles(2);
    check("t4_run_len", last_run, 16);
    check("t4_underrun", err_underrun, 1);
    check("t4_fif", frames_in_flight, 1);
    cycles(3);
    check("t4_sticky", err_underrun, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t4_clr", err_underrun, 0);

    // s_last on sample 10
    return_credits(16);
    send_frame(70, 0, 0, 10, 0);
    cycles(2);
    check("t5_framing", err_framing, 1);
    check("t5_run_len", last_run, 16);
    check("t5_fif", frames_in_flight, 2);
    // err_clr on the same cycle as a new framing error: set wins
    return_credits(16);
    send_frame(90, 0, 0, 3, 3);
    cycles(1);
    check("t5_set_wins", err_framing, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_clr", err_framing, 0);
    check("t5_fif3", frames_in_flight, 3);

    // Output valid drops at out_cnt = 7
    send_beats(7, 200, 1);
    fft_dout_valid = 1'b0;
    check("t6_align_pre", err_align, 0);
    step();
    check("t6_align", err_align, 1);
    check("t6_fif_drop", frames_in_flight, 2);
    send_beats(16, 300, 1);
    check("t6_fif_f1", frames_in_flight, 1);
    send_beats(16, 400, 1);
    fft_dout_valid = 1'b0;
    check("t6_fif_f2", frames_in_flight, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t6_clr", err_align, 0);
    // Stray output beat with nothing in flight
    send_beats(1, 500, 0);
    fft_dout_valid = 1'b0;
    check("stray_align", err_align, 1);
    check("stray_fif", frames_in_flight, 0);
    step();

    // Reset in the middle of a frame
    return_credits(16);
    for (int i = 1; i <= 5; i++) begin
      s_data  = sample(600 + i);
      s_valid = 1'b1;
      exp_din_q.push_back(s_data);
      step();
    end
    check("mid_fif", frames_in_flight, 1);
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    check("mid_rst_din_valid", fft_din_valid, 0);
    check("mid_rst_fif", frames_in_flight, 0);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_align", err_align, 0);
    cycles(2);
    rst_n = 1'b1;
    step();
    check("mid_rel_ready", s_ready, 1);
    check("mid_rel_din_valid", fft_din_valid, 0);
    cycles(2);

    check("din_q_left", exp_din_q.size(), 0);
    check("out_q_left", exp_out_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
